// File: rtl/display_pkg.sv
// Shared definitions for the display pipeline: controller state encoding and
// default 640x480-style timing constants at a 1600-clock line.
package display_pkg;

  typedef enum logic [1:0] {
    DEC_RST = 2'd0,
    IDLE    = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } dtc_state_e;

  localparam int DEF_HOR_FIELD      = 1279;
  localparam int DEF_HOR_STR_SYNC   = 1311;
  localparam int DEF_HOR_STP_SYNC   = 1503;
  localparam int DEF_HOR_TOTAL      = 1599;
  localparam int DEF_VER_FIELD      = 479;
  localparam int DEF_VER_STR_SYNC   = 489;
  localparam int DEF_VER_STP_SYNC   = 491;
  localparam int DEF_VER_TOTAL      = 520;
  localparam int DEF_DEC_RST_CYCLES = 270;

endpackage

// File: rtl/video_timing_counter.sv
// Pixel/line counters plus registered sync, blank and start-pulse decode.
// Counters run only while 'active'; decoded outputs trail the counters by 1.
module video_timing_counter
  import display_pkg::*;
#(
  parameter int HOR_FIELD    = DEF_HOR_FIELD,
  parameter int HOR_STR_SYNC = DEF_HOR_STR_SYNC,
  parameter int HOR_STP_SYNC = DEF_HOR_STP_SYNC,
  parameter int HOR_TOTAL    = DEF_HOR_TOTAL,
  parameter int VER_FIELD    = DEF_VER_FIELD,
  parameter int VER_STR_SYNC = DEF_VER_STR_SYNC,
  parameter int VER_STP_SYNC = DEF_VER_STP_SYNC,
  parameter int VER_TOTAL    = DEF_VER_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        frame_end,
  output logic        hs_n,
  output logic        vs_n,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);

  logic h_last;
  logic v_last;

  // End-of-line / end-of-frame detection on the live counter values
  always_comb begin
    h_last    = (hcount == 11'(HOR_TOTAL));
    v_last    = (vcount == 10'(VER_TOTAL));
    frame_end = active && h_last && v_last;
  end

  // Counters advance while scanning and park at the origin otherwise
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_last) begin
      hcount <= '0;
      vcount <= v_last ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // Registered decode of the current counter position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_n        <= 1'b1;
      vs_n        <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_n        <= !(active && hcount >= 11'(HOR_STR_SYNC) && hcount <= 11'(HOR_STP_SYNC));
      vs_n        <= !(active && vcount >= 10'(VER_STR_SYNC) && vcount <= 10'(VER_STP_SYNC));
      blank       <= !active || hcount > 11'(HOR_FIELD) || vcount > 10'(VER_FIELD);
      line_start  <= active && hcount == '0;
      frame_start <= active && hcount == '0 && vcount == '0;
    end
  end

endmodule

// File: rtl/display_timing_ctrl.sv
// Display timing controller: decoder reset sequencing, run/drain control of
// the raster counters, and the per-line fetch request handshake.
module display_timing_ctrl
  import display_pkg::*;
#(
  parameter int HOR_FIELD      = DEF_HOR_FIELD,
  parameter int HOR_STR_SYNC   = DEF_HOR_STR_SYNC,
  parameter int HOR_STP_SYNC   = DEF_HOR_STP_SYNC,
  parameter int HOR_TOTAL      = DEF_HOR_TOTAL,
  parameter int VER_FIELD      = DEF_VER_FIELD,
  parameter int VER_STR_SYNC   = DEF_VER_STR_SYNC,
  parameter int VER_STP_SYNC   = DEF_VER_STP_SYNC,
  parameter int VER_TOTAL      = DEF_VER_TOTAL,
  parameter int DEC_RST_CYCLES = DEF_DEC_RST_CYCLES
) (
  input  logic        TD_CLK27,
  input  logic        RESET_N,
  input  logic        EN,
  input  logic        FETCH_ACK,
  input  logic        UNDERRUN_CLR,
  output logic        TD_RESET_N,
  output logic        HS_N,
  output logic        VS_N,
  output logic        BLANK,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic [10:0] HCOUNT,
  output logic [9:0]  VCOUNT,
  output logic        FETCH_REQ,
  output logic [9:0]  FETCH_LINE,
  output logic        UNDERRUN,
  output logic        BUSY
);

  localparam int DW = (DEC_RST_CYCLES > 1) ? $clog2(DEC_RST_CYCLES) : 1;

  dtc_state_e    state;
  dtc_state_e    state_nxt;
  logic [DW-1:0] rst_cnt;
  logic          rst_done;
  logic          active;
  logic          frame_end;
  logic [9:0]    next_line;
  logic          fetch_due;
  logic          underrun_set;

  // Controller state register
  always_ff @(posedge TD_CLK27) begin
    if (!RESET_N) state <= DEC_RST;
    else          state <= state_nxt;
  end

  // Decoder reset hold-time counter, running only in DEC_RST
  always_ff @(posedge TD_CLK27) begin
    if (!RESET_N || state != DEC_RST) rst_cnt <= '0;
    else                              rst_cnt <= rst_cnt + DW'(1);
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    state_nxt  = state;
    rst_done   = (rst_cnt == DW'(DEC_RST_CYCLES - 1));
    active     = (state == RUN) || (state == DRAIN);
    TD_RESET_N = (state != DEC_RST);
    BUSY       = (state != IDLE);
    unique case (state)
      DEC_RST: if (rst_done) state_nxt = IDLE;
      IDLE:    if (EN) state_nxt = RUN;
      RUN:     if (!EN) state_nxt = DRAIN;
      DRAIN: begin
        if (EN)             state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = DEC_RST;
    endcase
  end

  video_timing_counter #(
    .HOR_FIELD    (HOR_FIELD),
    .HOR_STR_SYNC (HOR_STR_SYNC),
    .HOR_STP_SYNC (HOR_STP_SYNC),
    .HOR_TOTAL    (HOR_TOTAL),
    .VER_FIELD    (VER_FIELD),
    .VER_STR_SYNC (VER_STR_SYNC),
    .VER_STP_SYNC (VER_STP_SYNC),
    .VER_TOTAL    (VER_TOTAL)
  ) u_timing (
    .clk         (TD_CLK27),
    .rst_n       (RESET_N),
    .active      (active),
    .hcount      (HCOUNT),
    .vcount      (VCOUNT),
    .frame_end   (frame_end),
    .hs_n        (HS_N),
    .vs_n        (VS_N),
    .blank       (BLANK),
    .line_start  (LINE_START),
    .frame_start (FRAME_START)
  );

  // Fetch trigger and underrun detection; the request is launched on the
  // HOR_FIELD cycle so it is visible while HCOUNT shows HOR_FIELD+1
  always_comb begin
    next_line    = (VCOUNT == 10'(VER_TOTAL)) ? '0 : VCOUNT + 10'd1;
    fetch_due    = active && HCOUNT == 11'(HOR_FIELD) && next_line <= 10'(VER_FIELD);
    underrun_set = FETCH_REQ && !FETCH_ACK && HCOUNT == 11'(HOR_TOTAL);
  end

  // Fetch request handshake and sticky underrun flag
  always_ff @(posedge TD_CLK27) begin
    if (!RESET_N) begin
      FETCH_REQ  <= 1'b0;
      FETCH_LINE <= '0;
      UNDERRUN   <= 1'b0;
    end else begin
      if (FETCH_REQ) begin
        if (FETCH_ACK || underrun_set) FETCH_REQ <= 1'b0;
      end else if (fetch_due) begin
        FETCH_REQ  <= 1'b1;
        FETCH_LINE <= next_line;
      end
      if (underrun_set)      UNDERRUN <= 1'b1;
      else if (UNDERRUN_CLR) UNDERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Bench for display_timing_ctrl using a reduced raster (36x21) so full frames
// fit in a short run; decoder reset length kept at its default.
module tb_display_timing_ctrl;

  localparam int HF  = 23;
  localparam int HSS = 26;
  localparam int HSE = 30;
  localparam int HT  = 35;
  localparam int VF  = 13;
  localparam int VSS = 15;
  localparam int VSE = 17;
  localparam int VT  = 20;
  localparam int DRC = 270;
  localparam int H     = HT + 1;
  localparam int V     = VT + 1;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst_n, en, ack, clr;
  logic        td_rst_n, hs_n, vs_n, blank, line_start, frame_start;
  logic        fetch_req, underrun, busy;
  logic [10:0] hcount;
  logic [9:0]  vcount, fetch_line;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  display_timing_ctrl #(
    .HOR_FIELD      (HF),
    .HOR_STR_SYNC   (HSS),
    .HOR_STP_SYNC   (HSE),
    .HOR_TOTAL      (HT),
    .VER_FIELD      (VF),
    .VER_STR_SYNC   (VSS),
    .VER_STP_SYNC   (VSE),
    .VER_TOTAL      (VT),
    .DEC_RST_CYCLES (DRC)
  ) dut (
    .TD_CLK27     (clk),
    .RESET_N      (rst_n),
    .EN           (en),
    .FETCH_ACK    (ack),
    .UNDERRUN_CLR (clr),
    .TD_RESET_N   (td_rst_n),
    .HS_N         (hs_n),
    .VS_N         (vs_n),
    .BLANK        (blank),
    .LINE_START   (line_start),
    .FRAME_START  (frame_start),
    .HCOUNT       (hcount),
    .VCOUNT       (vcount),
    .FETCH_REQ    (fetch_req),
    .FETCH_LINE   (fetch_line),
    .UNDERRUN     (underrun),
    .BUSY         (busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: frame position as one integer, outputs by arithmetic
  int m_mode = 0;   // 0 decoder reset, 1 idle, 2 running, 3 draining
  int m_left = DRC;
  int m_pos  = 0;
  int m_line = 0;
  bit m_req  = 1'b0;
  bit m_ur   = 1'b0;
  bit e_hs_n = 1'b1, e_vs_n = 1'b1, e_blank = 1'b1, e_ls = 1'b0, e_fs = 1'b0;

  task automatic model_step();
    int h, v, nl;
    bit act, new_ur, last;
    if (!rst_n) begin
      m_mode = 0; m_left = DRC; m_pos = 0; m_req = 0; m_line = 0; m_ur = 0;
      e_hs_n = 1; e_vs_n = 1; e_blank = 1; e_ls = 0; e_fs = 0;
    end else begin
      act = (m_mode >= 2);
      h = m_pos % H;
      v = m_pos / H;
      e_hs_n  = !(act && h >= HSS && h <= HSE);
      e_vs_n  = !(act && v >= VSS && v <= VSE);
      e_blank = !act || h > HF || v > VF;
      e_ls    = act && h == 0;
      e_fs    = act && m_pos == 0;
      nl = (v + 1) % V;
      new_ur = 0;
      if (m_req) begin
        if (ack) m_req = 0;
        else if (h == HT) begin m_req = 0; new_ur = 1; end
      end else if (act && h == HF && nl <= VF) begin
        m_req = 1; m_line = nl;
      end
      if (new_ur) m_ur = 1;
      else if (clr) m_ur = 0;
      last = (m_pos == FRAME - 1);
      if (act) m_pos = (m_pos + 1) % FRAME;
      case (m_mode)
        0: begin m_left--; if (m_left == 0) m_mode = 1; end
        1: if (en) m_mode = 2;
        2: if (!en) m_mode = 3;
        default: if (en) m_mode = 2; else if (last) m_mode = 1;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model
  bit chk_on = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check_val("td_reset_n",  int'(td_rst_n),    int'(m_mode != 0));
      check_val("busy",        int'(busy),        int'(m_mode != 1));
      check_val("hcount",      int'(hcount),      m_pos % H);
      check_val("vcount",      int'(vcount),      m_pos / H);
      check_val("hs_n",        int'(hs_n),        int'(e_hs_n));
      check_val("vs_n",        int'(vs_n),        int'(e_vs_n));
      check_val("blank",       int'(blank),       int'(e_blank));
      check_val("line_start",  int'(line_start),  int'(e_ls));
      check_val("frame_start", int'(frame_start), int'(e_fs));
      check_val("fetch_req",   int'(fetch_req),   int'(m_req));
      check_val("fetch_line",  int'(fetch_line),  m_line);
      check_val("underrun",    int'(underrun),    int'(m_ur));
    end
  end

  // Fetch responder: 0 random latency, 1 fixed latency, 2 withhold
  int ack_mode = 0;
  int ack_fix  = 5;
  initial begin
    int cnt = 0;
    int d = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (fetch_req) begin
        if (cnt == 0) d = (ack_mode == 0) ? int'($urandom_range(0, 14)) : ack_fix;
        ack = (ack_mode != 2) && (cnt == d);
        cnt++;
      end else begin
        cnt = 0;
        ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic wait_pos(input int h, input int v, input string tag);
    int n = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && n < 3 * FRAME) begin
      tick(); n++;
    end
    check_val({tag, "_reached"}, int'(int'(hcount) == h && int'(vcount) == v), 1);
  endtask

  task automatic wait_req(input bit lvl, input string tag);
    int n = 0;
    while (fetch_req != lvl && n < 2 * H) begin tick(); n++; end
    check_val(tag, int'(fetch_req), int'(lvl));
  endtask

  task automatic check_reset_state(input string p);
    check_val({p, "_td_reset_n"},  int'(td_rst_n),    0);
    check_val({p, "_busy"},        int'(busy),        1);
    check_val({p, "_hcount"},      int'(hcount),      0);
    check_val({p, "_vcount"},      int'(vcount),      0);
    check_val({p, "_hs_n"},        int'(hs_n),        1);
    check_val({p, "_vs_n"},        int'(vs_n),        1);
    check_val({p, "_blank"},       int'(blank),       1);
    check_val({p, "_line_start"},  int'(line_start),  0);
    check_val({p, "_frame_start"}, int'(frame_start), 0);
    check_val({p, "_fetch_req"},   int'(fetch_req),   0);
    check_val({p, "_fetch_line"},  int'(fetch_line),  0);
    check_val({p, "_underrun"},    int'(underrun),    0);
  endtask

  initial begin
    int n, p, ls_cnt, fs_cnt, hs_lo, vs_lo, gap_min, gap_max, last_ls;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    tick(3);
    check_reset_state("rst");

    // Decoder reset hold time after release
    rst_n = 1'b1;
    n = 0;
    while (td_rst_n == 1'b0 && n < 2 * DRC) begin n++; tick(); end
    check_val("dec_rst_len", n, DRC);
    tick(3);
    check_val("idle_busy", int'(busy), 0);
    check_val("idle_hs_n", int'(hs_n), 1);

    // Start: first FRAME_START two negedges after EN (IDLE->RUN, then decode)
    en = 1'b1;
    n = 0;
    while (!frame_start && n < 10) begin tick(); n++; end
    check_val("first_fs_latency", n, 2);
    check_val("first_fs_hcount", int'(hcount), 1);

    // One full frame of timing statistics
    ls_cnt = 0; fs_cnt = 0; hs_lo = 0; vs_lo = 0;
    gap_min = 1 << 30; gap_max = 0; last_ls = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (line_start) begin
        if (last_ls >= 0) begin
          if (i - last_ls < gap_min) gap_min = i - last_ls;
          if (i - last_ls > gap_max) gap_max = i - last_ls;
        end
        last_ls = i;
        ls_cnt++;
      end
      if (frame_start) fs_cnt++;
      if (!hs_n) hs_lo++;
      if (!vs_n) vs_lo++;
      tick();
    end
    check_val("frame_line_starts", ls_cnt, V);
    check_val("frame_frame_starts", fs_cnt, 1);
    check_val("line_period_min", gap_min, H);
    check_val("line_period_max", gap_max, H);
    check_val("hs_low_per_frame", hs_lo, V * (HSE - HSS + 1));
    check_val("vs_low_per_frame", vs_lo, H * (VSE - VSS + 1));

    // ACK five clocks after the request issued on line 10
    ack_mode = 1; ack_fix = 5;
    tick(H);
    clr = 1'b1; tick(); clr = 1'b0;
    wait_pos(HF + 1, 10, "ack5");
    check_val("ack5_req_up", int'(fetch_req), 1);
    check_val("ack5_line", int'(fetch_line), 11);
    n = 0;
    while (fetch_req && n < H) begin tick(); n++; end
    check_val("ack5_req_cycles", n, 6);
    check_val("ack5_underrun", int'(underrun), 0);

    // ACK exactly on the HOR_TOTAL cycle wins over underrun
    wait_pos(0, 6, "ack_last");
    ack_fix = HT - HF - 1;
    wait_req(1'b1, "ack_last_req_up");
    n = 0;
    while (fetch_req && n < H) begin tick(); n++; end
    check_val("ack_last_req_cycles", n, HT - HF);
    check_val("ack_last_underrun", int'(underrun), 0);

    // Withheld ACK on the last line: request for line 0 times out
    wait_pos(0, VT, "withhold");
    ack_mode = 2;
    wait_req(1'b1, "withhold_req_up");
    check_val("withhold_line", int'(fetch_line), 0);
    n = 0;
    while (fetch_req && n < H) begin tick(); n++; end
    check_val("withhold_req_cycles", n, HT - HF);
    check_val("withhold_underrun", int'(underrun), 1);
    check_val("withhold_wrap_h", int'(hcount), 0);
    ack_mode = 1; ack_fix = 5;
    tick(3);
    check_val("underrun_sticky", int'(underrun), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_val("underrun_cleared", int'(underrun), 0);

    // A new underrun beats a simultaneous clear
    wait_pos(0, 5, "setwins");
    ack_mode = 2; clr = 1'b1;
    wait_req(1'b1, "setwins_req_up");
    wait_req(1'b0, "setwins_req_down");
    check_val("setwins_underrun", int'(underrun), 1);
    clr = 1'b0; ack_mode = 0;

    // Drain from line 8 runs to the end of the frame, then idles
    wait_pos(5, 8, "drain");
    p = 8 * H + 5;
    en = 1'b0;
    n = 0;
    while (busy && n < 2 * FRAME) begin tick(); n++; end
    check_val("drain_cycles", n, FRAME - p);
    check_val("drain_hcount", int'(hcount), 0);
    check_val("drain_vcount", int'(vcount), 0);
    tick(2);
    check_val("drain_idle_blank", int'(blank), 1);
    check_val("drain_idle_req", int'(fetch_req), 0);

    // Drain interrupted by EN: scanning continues undisturbed
    en = 1'b1;
    wait_pos(0, 3, "resume");
    en = 1'b0;
    tick(40);
    en = 1'b1;
    check_val("resume_busy", int'(busy), 1);
    check_val("resume_hcount", int'(hcount), (3 * H + 40) % H);
    check_val("resume_vcount", int'(vcount), (3 * H + 40) / H);

    // Reset mid-frame
    wait_pos(17, 9, "midrst");
    rst_n = 1'b0;
    tick();
    check_reset_state("midrst");
    rst_n = 1'b1;
    n = 0;
    while (td_rst_n == 1'b0 && n < 2 * DRC) begin n++; tick(); end
    check_val("midrst_dec_rst_len", n, DRC);

    // Randomized run: EN toggles, clears, rare resets, random ACK latency
    ack_mode = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      clr   = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 2499) != 0);
      tick();
    end
    rst_n = 1'b1; clr = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
